// File: rtl/pong_ball_sound.sv
// pong_ball_sound: pong ball mover with wall/paddle reflection, miss detection and hit beeper.
// Optional RANDOM_BOUNCE_EN: paddle reflections pick a new vertical direction from entropy[0].
module pong_ball_sound #(
    parameter int STEP_BASE = 8,
    parameter int TONE_LEN  = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ball_reset,
    input  logic [4:0]  entropy,
    input  logic [3:0]  speed,
    input  logic [31:0] lpaddle,
    input  logic [31:0] rpaddle,
    output logic [4:0]  x,
    output logic [4:0]  y,
    output logic        paddle_hit,
    output logic        wall_hit,
    output logic        out_left,
    output logic        out_right,
    output logic        buzzer
);
    localparam int CW = $clog2(15 * STEP_BASE + 1);
    localparam int TW = $clog2(TONE_LEN + 1);
    logic [4:0]    x_q, x_d, y_q, y_d;
    logic          dx_q, dx_d, dy_q, dy_d;
    logic [CW-1:0] cnt_q, cnt_d, last;
    logic          paddle_hit_q, paddle_hit_d, wall_hit_q, wall_hit_d;
    logic          out_left_q, out_left_d, out_right_q, out_right_d;
    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic          tone_sel_q, tone_sel_d, ph_q, ph_d, buzzer_q, buzzer_d;
    logic          move, trig;
    assign last = CW'((32'd16 - 32'(speed)) * 32'(STEP_BASE) - 32'd1);
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        dx_d = dx_q;
        dy_d = dy_q;
        cnt_d = cnt_q;
        paddle_hit_d = 1'b0;
        wall_hit_d = 1'b0;
        out_left_d = out_left_q;
        out_right_d = out_right_q;
        move = 1'b0;
        if (ball_reset) begin
            x_d = 5'd16;
            y_d = 5'd8 + {1'b0, entropy[3:0]};
            dx_d = entropy[4];
            dy_d = entropy[0];
            cnt_d = '0;
            out_left_d = 1'b0;
            out_right_d = 1'b0;
        end else if (speed == 4'd0 || out_left_q || out_right_q) begin
            cnt_d = '0;
        end else if (cnt_q >= last) begin
            cnt_d = '0;
            move = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (move) begin
            if ((y_q == 5'd0 && !dy_q) || (y_q == 5'd31 && dy_q)) begin
                dy_d = ~dy_q;
                y_d = dy_q ? 5'd30 : 5'd1;
                wall_hit_d = 1'b1;
            end else begin
                y_d = dy_q ? y_q + 5'd1 : y_q - 5'd1;
            end
            // horizontal decisions look at the row the ball occupied before this move
            if (x_q == 5'd1 && !dx_q) begin
                dx_d = lpaddle[y_q] ? 1'b1 : dx_q;
                x_d = lpaddle[y_q] ? 5'd2 : 5'd0;
                paddle_hit_d = lpaddle[y_q];
                out_left_d = !lpaddle[y_q];
            end else if (x_q == 5'd30 && dx_q) begin
                dx_d = rpaddle[y_q] ? 1'b0 : dx_q;
                x_d = rpaddle[y_q] ? 5'd29 : 5'd31;
                paddle_hit_d = rpaddle[y_q];
                out_right_d = !rpaddle[y_q];
            end else begin
                x_d = dx_q ? x_q + 5'd1 : x_q - 5'd1;
            end
`ifdef RANDOM_BOUNCE_EN
            if (paddle_hit_d) dy_d = entropy[0];
`else
`endif
        end
    end
    // ph_q halves the toggle rate for the low (wall) tone
    always_comb begin
        trig = speed != 4'd0 && (paddle_hit_q || wall_hit_q);
        tone_cnt_d = trig ? TW'(TONE_LEN) : (tone_cnt_q != '0 ? tone_cnt_q - 1'b1 : '0);
        tone_sel_d = trig ? paddle_hit_q : tone_sel_q;
        ph_d = !trig && tone_cnt_q != '0 && !ph_q;
        buzzer_d = (trig || tone_cnt_q == '0) ? 1'b0 : ((tone_sel_q || ph_q) ? ~buzzer_q : buzzer_q);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= 5'd16;
            y_q <= 5'd16;
            dx_q <= 1'b1;
            dy_q <= 1'b1;
            cnt_q <= '0;
            paddle_hit_q <= 1'b0;
            wall_hit_q <= 1'b0;
            out_left_q <= 1'b0;
            out_right_q <= 1'b0;
            tone_cnt_q <= '0;
            tone_sel_q <= 1'b0;
            ph_q <= 1'b0;
            buzzer_q <= 1'b0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            cnt_q <= cnt_d;
            paddle_hit_q <= paddle_hit_d;
            wall_hit_q <= wall_hit_d;
            out_left_q <= out_left_d;
            out_right_q <= out_right_d;
            tone_cnt_q <= tone_cnt_d;
            tone_sel_q <= tone_sel_d;
            ph_q <= ph_d;
            buzzer_q <= buzzer_d;
        end
    end
    assign x = x_q;
    assign y = y_q;
    assign paddle_hit = paddle_hit_q;
    assign wall_hit = wall_hit_q;
    assign out_left = out_left_q;
    assign out_right = out_right_q;
    assign buzzer = buzzer_q;
endmodule

// File: tb/tb_pong_ball_sound.sv
// tb_pong_ball_sound: directed checks of ball movement, reflections, misses and the hit beeper.
module tb_pong_ball_sound;
    logic        clk = 1'b0;
    logic        reset, ball_reset;
    logic [4:0]  entropy;
    logic [3:0]  speed;
    logic [31:0] lpaddle, rpaddle;
    logic [4:0]  x, y;
    logic        paddle_hit, wall_hit, out_left, out_right, buzzer;
    int checks = 0;
    int errors = 0;

    pong_ball_sound dut (
        .clk(clk), .reset(reset), .ball_reset(ball_reset), .entropy(entropy), .speed(speed),
        .lpaddle(lpaddle), .rpaddle(rpaddle), .x(x), .y(y), .paddle_hit(paddle_hit),
        .wall_hit(wall_hit), .out_left(out_left), .out_right(out_right), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic serve(input logic [4:0] e);
        ball_reset = 1'b1;
        entropy = e;
        tick(1);
        ball_reset = 1'b0;
    endtask

    task automatic ticks_to_move(output int n);
        logic [4:0] x0;
        x0 = x;
        n = 0;
        while (x == x0 && n < 300) begin
            tick(1);
            n++;
        end
    endtask

    task automatic count_toggles(input int n, output int t);
        logic p;
        p = buzzer;
        t = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (buzzer != p) t++;
            p = buzzer;
        end
    endtask

    initial begin
        int n, bad;
        reset = 1'b1;
        ball_reset = 1'b0;
        entropy = '0;
        speed = 4'd0;
        lpaddle = '0;
        rpaddle = '0;
        tick(2);
        reset = 1'b0;
        check("rst_x", x, 16);
        check("rst_y", y, 16);
        check("rst_flags", {paddle_hit, wall_hit, out_left, out_right, buzzer}, 0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (x != 16 || y != 16 || buzzer || paddle_hit || wall_hit) bad++;
        end
        check("frozen", bad, 0);

        speed = 4'd15;
        ticks_to_move(n);
        check("int15_a", n, 8);
        check("first_x", x, 17);
        check("first_y", y, 17);
        ticks_to_move(n);
        check("int15_b", n, 8);
        speed = 4'd1;
        ticks_to_move(n);
        check("int1", n, 120);
        speed = 4'd15;

        serve(5'b10011);
        check("serve_x", x, 16);
        check("serve_y", y, 11);
        tick(8);
        check("serve_mv_x", x, 17);
        check("serve_mv_y", y, 12);

        serve(5'b00000);
        tick(64);
        check("wall_pre_y", y, 0);
        check("wall_pre_x", x, 8);
        check("wall_pre_pulse", wall_hit, 0);
        tick(8);
        check("wall_y", y, 1);
        check("wall_x", x, 7);
        check("wall_pulse", wall_hit, 1);
        tick(1);
        check("wall_pulse_end", wall_hit, 0);
        count_toggles(54, n);
        check("low_toggles", n, 26);
        check("low_idle", buzzer, 0);

        serve(5'b00001);
        lpaddle = 32'h0100_0000;
        tick(120);
        check("pad_pre_x", x, 1);
        check("pad_pre_y", y, 24);
        tick(8);
        check("pad_x", x, 2);
        check("pad_y", y, 25);
        check("pad_pulse", paddle_hit, 1);
        check("pad_no_wall", wall_hit, 0);
        tick(1);
        check("pad_pulse_end", paddle_hit, 0);
        count_toggles(54, n);
        check("high_toggles", n, 50);
        check("high_idle", buzzer, 0);

        serve(5'b00001);
        lpaddle = '0;
        tick(128);
        check("miss_x", x, 0);
        check("miss_y", y, 25);
        check("miss_out", out_left, 1);
        check("miss_no_pulse", paddle_hit, 0);
        tick(40);
        check("miss_hold_x", x, 0);
        check("miss_hold_y", y, 25);
        check("miss_hold_out", out_left, 1);
        check("miss_no_beep", buzzer, 0);
        serve(5'b10011);
        check("miss_clr", out_left, 0);
        check("miss_clr_y", y, 11);

        serve(5'b10110);
        rpaddle = 32'h0000_0001;
        tick(112);
        check("corner_pre_x", x, 30);
        check("corner_pre_y", y, 0);
        tick(8);
        check("corner_x", x, 29);
        check("corner_y", y, 1);
        check("corner_pulses", {paddle_hit, wall_hit}, 3);
        check("corner_no_out", out_right, 0);
        tick(1);
        count_toggles(54, n);
        check("corner_toggles", n, 50);

        serve(5'b00000);
        tick(72);
        check("quiet_pulse", wall_hit, 1);
        speed = 4'd0;
        bad = 0;
        for (int i = 0; i < 54; i++) begin
            tick(1);
            if (buzzer) bad++;
        end
        check("quiet_beep", bad, 0);
        check("quiet_x", x, 7);
        check("quiet_y", y, 1);

        speed = 4'd15;
        serve(5'b00000);
        tick(72);
        tick(4);
        check("beep_on", buzzer, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("beep_reset", buzzer, 0);
        check("beep_reset_x", x, 16);
        check("beep_reset_y", y, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
